// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// adds bounded memory wait states and precise exceptions (illegal op, bus timeout, overflow).
module multicycle_control #(
  parameter int ALUOP_W    = 2,
  parameter int MEM_TO_W   = 4,
  parameter int MEM_TO_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         iOp,
  input  logic               iZero,
  input  logic               iOverflow,
  input  logic               iMemReady,
  output logic               oPCWr,
  output logic               oIRWr,
  output logic               oIorD,
  output logic               oMemRd,
  output logic               oMemWr,
  output logic               oRegDst,
  output logic               oMemtoReg,
  output logic               oRegWr,
  output logic               oALUSrcA,
  output logic [1:0]         oALUSrcB,
  output logic [ALUOP_W-1:0] oALUOp,
  output logic [1:0]         oPCSrc,
  output logic               oException,
  output logic [1:0]         oExcCause,
  output logic [3:0]         oState
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b11;

  localparam logic [MEM_TO_W-1:0] TO_LIMIT = MEM_TO_W'(MEM_TO_MAX);

  typedef enum logic [3:0] {
    S_RESET  = 4'b0000,
    S_FETCH  = 4'b0001,
    S_DECODE = 4'b0010,
    S_MEMADR = 4'b0011,
    S_MEMRD  = 4'b0100,
    S_MEMWB  = 4'b0101,
    S_MEMWR  = 4'b0110,
    S_EXEC   = 4'b0111,
    S_ALUWB  = 4'b1000,
    S_BRANCH = 4'b1001,
    S_JUMP   = 4'b1010,
    S_ADDIEX = 4'b1011,
    S_ADDIWB = 4'b1100,
    S_EXC    = 4'b1101
  } state_t;

  state_t              state;
  logic [MEM_TO_W-1:0] wait_cnt;
  logic [1:0]          exc_cause;
  logic [5:0]          op_reg;
  logic [1:0]          alu_op;
  logic                at_limit;

  assign at_limit  = (wait_cnt == TO_LIMIT);
  assign oState    = state;
  assign oExcCause = exc_cause;

  // State, wait counter, latched opcode and exception cause
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RESET;
      wait_cnt  <= '0;
      exc_cause <= 2'b00;
      op_reg    <= 6'b000000;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_RESET: state <= S_FETCH;
        // Shared wait-state handling: ready beats timeout on the same cycle
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (iMemReady) begin
            case (state)
              S_FETCH: state <= S_DECODE;
              S_MEMRD: state <= S_MEMWB;
              default: state <= S_FETCH;
            endcase
          end else if (at_limit) begin
            state     <= S_EXC;
            exc_cause <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          op_reg <= iOp;
          case (iOp)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            OP_ADDI:      state <= S_ADDIEX;
            default: begin
              state     <= S_EXC;
              exc_cause <= CAUSE_ILLEGAL;
            end
          endcase
        end
        S_MEMADR: state <= (op_reg == OP_SW) ? S_MEMWR : S_MEMRD;
        S_EXEC:   state <= S_ALUWB;
        S_ADDIEX: state <= S_ADDIWB;
        S_ALUWB, S_ADDIWB: begin
          if (iOverflow) begin
            state     <= S_EXC;
            exc_cause <= CAUSE_OVERFLOW;
          end else begin
            state <= S_FETCH;
          end
        end
        S_MEMWB, S_BRANCH, S_JUMP, S_EXC: state <= S_FETCH;
        default: state <= S_RESET;
      endcase
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    oPCWr      = 1'b0;
    oIRWr      = 1'b0;
    oIorD      = 1'b0;
    oMemRd     = 1'b0;
    oMemWr     = 1'b0;
    oRegDst    = 1'b0;
    oMemtoReg  = 1'b0;
    oRegWr     = 1'b0;
    oALUSrcA   = 1'b0;
    oALUSrcB   = 2'b00;
    alu_op     = 2'b00;
    oPCSrc     = 2'b00;
    oException = 1'b0;
    case (state)
      S_FETCH: begin
        oMemRd   = 1'b1;
        oALUSrcB = 2'b01;
        oIRWr    = iMemReady;
        oPCWr    = iMemReady;
      end
      S_DECODE: oALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        oALUSrcA = 1'b1;
        oALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        oIorD  = 1'b1;
        oMemRd = 1'b1;
      end
      S_MEMWB: begin
        oMemtoReg = 1'b1;
        oRegWr    = 1'b1;
      end
      S_MEMWR: begin
        oIorD  = 1'b1;
        oMemWr = 1'b1;
      end
      S_EXEC: begin
        oALUSrcA = 1'b1;
        alu_op   = 2'b10;
      end
      S_ALUWB: begin
        oRegDst = 1'b1;
        oRegWr  = ~iOverflow;
      end
      S_ADDIWB: oRegWr = ~iOverflow;
      S_BRANCH: begin
        oALUSrcA = 1'b1;
        alu_op   = 2'b01;
        oPCSrc   = 2'b01;
        oPCWr    = iZero;
      end
      S_JUMP: begin
        oPCSrc = 2'b10;
        oPCWr  = 1'b1;
      end
      S_EXC: begin
        oException = 1'b1;
        oPCSrc     = 2'b11;
        oPCWr      = 1'b1;
      end
      default: oPCWr = 1'b0;
    endcase
  end

  // Upper ALUOp bits are always zero
  always_comb begin
    oALUOp      = '0;
    oALUOp[1:0] = alu_op;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control with a per-cycle expected-value scoreboard
// and hand-written sequences for timeout, ready-at-limit and reset-during-access.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] iOp;
  logic       iZero, iOverflow, iMemReady;
  logic       oPCWr, oIRWr, oIorD, oMemRd, oMemWr, oRegDst, oMemtoReg, oRegWr, oALUSrcA;
  logic [1:0] oALUSrcB, oALUOp, oPCSrc, oExcCause;
  logic       oException;
  logic [3:0] oState;

  multicycle_control dut (
    .clk(clk), .reset(reset), .iOp(iOp), .iZero(iZero), .iOverflow(iOverflow),
    .iMemReady(iMemReady), .oPCWr(oPCWr), .oIRWr(oIRWr), .oIorD(oIorD),
    .oMemRd(oMemRd), .oMemWr(oMemWr), .oRegDst(oRegDst), .oMemtoReg(oMemtoReg),
    .oRegWr(oRegWr), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB), .oALUOp(oALUOp),
    .oPCSrc(oPCSrc), .oException(oException), .oExcCause(oExcCause), .oState(oState)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, ILL = 6'b111111;
  localparam logic [3:0] S_RST = 4'd0, S_F = 4'd1, S_D = 4'd2, S_MA = 4'd3, S_MR = 4'd4;
  localparam logic [3:0] S_MWB = 4'd5, S_MW = 4'd6, S_EX = 4'd7, S_AWB = 4'd8, S_BR = 4'd9;
  localparam logic [3:0] S_J = 4'd10, S_AEX = 4'd11, S_IWB = 4'd12, S_EXC = 4'd13;

  // ctl = {reset, iZero, iOverflow, iMemReady}
  typedef struct {
    logic [3:0]  ctl;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [15:0] outs;
    logic [1:0]  cause;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] outs;
    logic [1:0]  cause;
    int          id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [15:0] E_ZERO, E_F_RDY, E_F_WAIT, E_DEC, E_MA, E_MR, E_MWB, E_MW, E_EX;
  logic [15:0] E_AWB, E_AWB_OV, E_IWB, E_BR_T, E_BR_N, E_J, E_EXC;

  function automatic logic [15:0] ob(input logic pcwr, irwr, iord, memrd, memwr,
                                     regdst, memtoreg, regwr, srca,
                                     input logic [1:0] srcb, aluop, pcsrc,
                                     input logic exc);
    return {pcwr, irwr, iord, memrd, memwr, regdst, memtoreg, regwr, srca,
            srcb, aluop, pcsrc, exc};
  endfunction

  function automatic vec_t mk(input logic [3:0] ctl, input logic [5:0] op,
                              input logic [3:0] st, input logic [15:0] outs,
                              input logic [1:0] cause);
    vec_t v;
    v.ctl = ctl; v.op = op; v.st = st; v.outs = outs; v.cause = cause;
    return v;
  endfunction

  task automatic row(input logic [3:0] ctl, input logic [5:0] op, input logic [3:0] st,
                     input logic [15:0] outs, input logic [1:0] cause);
    tbl.push_back(mk(ctl, op, st, outs, cause));
  endtask

  // One clock: drive inputs after the edge, record expectation, compare at the falling edge
  task automatic step(input vec_t v, input int id);
    exp_t        e;
    logic [15:0] act;
    @(posedge clk);
    #1;
    {reset, iZero, iOverflow, iMemReady} = v.ctl;
    iOp = v.op;
    e.st = v.st; e.outs = v.outs; e.cause = v.cause; e.id = id;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    act = {oPCWr, oIRWr, oIorD, oMemRd, oMemWr, oRegDst, oMemtoReg, oRegWr, oALUSrcA,
           oALUSrcB, oALUOp, oPCSrc, oException};
    tests++;
    if (oState !== e.st || act !== e.outs || oExcCause !== e.cause) begin
      fails++;
      $display("FAIL step%0d: got state=%b outs=%b cause=%b, expected state=%b outs=%b cause=%b",
               e.id, oState, act, oExcCause, e.st, e.outs, e.cause);
    end
    tests++;
    if ((oMemRd && oMemWr) || (oRegWr && !(oState inside {S_MWB, S_AWB, S_IWB}))) begin
      fails++;
      $display("FAIL invariant%0d: got state=%b memrd=%b memwr=%b regwr=%b, expected exclusive rd/wr and regwr only in writeback",
               e.id, oState, oMemRd, oMemWr, oRegWr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expired, expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; iOp = RT; iZero = 1'b0; iOverflow = 1'b0; iMemReady = 1'b0;

    E_ZERO   = 16'h0000;
    E_F_RDY  = ob(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
    E_F_WAIT = ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
    E_DEC    = ob(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0);
    E_MA     = ob(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0);
    E_MR     = ob(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    E_MWB    = ob(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
    E_MW     = ob(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    E_EX     = ob(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0);
    E_AWB    = ob(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
    E_AWB_OV = ob(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    E_IWB    = ob(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
    E_BR_T   = ob(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0);
    E_BR_N   = ob(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0);
    E_J      = ob(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0);
    E_EXC    = ob(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b11,1'b1);

    // Reset, then LW
    row(4'b1001, RT,   S_RST, E_ZERO,   2'd0);
    row(4'b0001, LW,   S_RST, E_ZERO,   2'd0);
    row(4'b0001, LW,   S_F,   E_F_RDY,  2'd0);
    row(4'b0001, LW,   S_D,   E_DEC,    2'd0);
    row(4'b0001, LW,   S_MA,  E_MA,     2'd0);
    row(4'b0001, LW,   S_MR,  E_MR,     2'd0);
    row(4'b0001, LW,   S_MWB, E_MWB,    2'd0);
    // R-type
    row(4'b0001, RT,   S_F,   E_F_RDY,  2'd0);
    row(4'b0001, RT,   S_D,   E_DEC,    2'd0);
    row(4'b0001, RT,   S_EX,  E_EX,     2'd0);
    row(4'b0001, RT,   S_AWB, E_AWB,    2'd0);
    // SW
    row(4'b0001, SW,   S_F,   E_F_RDY,  2'd0);
    row(4'b0001, SW,   S_D,   E_DEC,    2'd0);
    row(4'b0001, SW,   S_MA,  E_MA,     2'd0);
    row(4'b0001, SW,   S_MW,  E_MW,     2'd0);
    // BEQ taken, then not taken
    row(4'b0101, BEQ,  S_F,   E_F_RDY,  2'd0);
    row(4'b0101, BEQ,  S_D,   E_DEC,    2'd0);
    row(4'b0101, BEQ,  S_BR,  E_BR_T,   2'd0);
    row(4'b0001, BEQ,  S_F,   E_F_RDY,  2'd0);
    row(4'b0001, BEQ,  S_D,   E_DEC,    2'd0);
    row(4'b0001, BEQ,  S_BR,  E_BR_N,   2'd0);
    // J
    row(4'b0001, JMP,  S_F,   E_F_RDY,  2'd0);
    row(4'b0001, JMP,  S_D,   E_DEC,    2'd0);
    row(4'b0001, JMP,  S_J,   E_J,      2'd0);
    // Illegal opcode
    row(4'b0001, ILL,  S_F,   E_F_RDY,  2'd0);
    row(4'b0001, ILL,  S_D,   E_DEC,    2'd0);
    row(4'b0001, ILL,  S_EXC, E_EXC,    2'd1);
    // ADDI without and with overflow
    row(4'b0001, ADDI, S_F,   E_F_RDY,  2'd1);
    row(4'b0001, ADDI, S_D,   E_DEC,    2'd1);
    row(4'b0001, ADDI, S_AEX, E_MA,     2'd1);
    row(4'b0001, ADDI, S_IWB, E_IWB,    2'd1);
    row(4'b0001, ADDI, S_F,   E_F_RDY,  2'd1);
    row(4'b0001, ADDI, S_D,   E_DEC,    2'd1);
    row(4'b0001, ADDI, S_AEX, E_MA,     2'd1);
    row(4'b0011, ADDI, S_IWB, E_ZERO,   2'd1);
    row(4'b0001, ADDI, S_EXC, E_EXC,    2'd3);
    // R-type overflow
    row(4'b0001, RT,   S_F,   E_F_RDY,  2'd3);
    row(4'b0001, RT,   S_D,   E_DEC,    2'd3);
    row(4'b0001, RT,   S_EX,  E_EX,     2'd3);
    row(4'b0011, RT,   S_AWB, E_AWB_OV, 2'd3);
    row(4'b0001, RT,   S_EXC, E_EXC,    2'd3);

    foreach (tbl[i]) step(tbl[i], i);

    // Fetch timeout: 16 waiting cycles, then a bus-timeout exception
    for (int i = 0; i < 16; i++) step(mk(4'b0000, LW, S_F, E_F_WAIT, 2'd3), 100 + i);
    step(mk(4'b0000, LW, S_EXC, E_EXC, 2'd2), 116);
    // Ready arriving on the 16th cycle completes normally
    for (int i = 0; i < 15; i++) step(mk(4'b0000, LW, S_F, E_F_WAIT, 2'd2), 200 + i);
    step(mk(4'b0001, LW, S_F,  E_F_RDY, 2'd2), 215);
    step(mk(4'b0001, LW, S_D,  E_DEC,   2'd2), 216);
    step(mk(4'b0001, LW, S_MA, E_MA,    2'd2), 217);
    // Reset in the middle of a stalled load
    for (int i = 0; i < 3; i++) step(mk(4'b0000, LW, S_MR, E_MR, 2'd2), 300 + i);
    step(mk(4'b1000, LW, S_MR,  E_MR,    2'd2), 303);
    step(mk(4'b0001, LW, S_RST, E_ZERO,  2'd0), 304);
    step(mk(4'b0001, LW, S_F,   E_F_RDY, 2'd0), 305);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
